// File: rtl/retire_trace_buf.sv
// retire_trace_buf
// ----------------
// Captures one record per retiring R-type or I-type instruction into a small
// circular buffer and presents the oldest record to a lockstep checker over a
// valid/ready handshake. It also spots the end-of-program syscall and asks the
// core to stall before the buffer can overflow.
//
// Ports
//   clk, reset              clock; synchronous active-low reset
//   ret_*                   retirement record from the core writeback stage
//   ret_v0                  current value of $2, used by halt detection
//   out_valid / out_ready   handshake for the head record
//   out_*                   head record fields (don't-care while out_valid=0)
//   stall_req               registered request: core must not retire next cycle
//   overflow                sticky: a record was dropped on a full buffer
//   halt                    sticky: end-of-program retirement seen
//   drained                 halt set and buffer empty
//   retired_cnt             records accepted into the buffer (wraps at 2^32)
module retire_trace_buf #(
  parameter int unsigned DEPTH      = 8,
  parameter logic [31:0] HALT_INSTR = 32'h0000000c,
  parameter logic [31:0] HALT_V0    = 32'h0000000a
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ret_valid,
  input  logic        ret_is_r,
  input  logic        ret_is_i,
  input  logic [31:0] ret_pc,
  input  logic [31:0] ret_instr,
  input  logic [4:0]  ret_rd,
  input  logic [4:0]  ret_rs,
  input  logic [4:0]  ret_rt,
  input  logic [31:0] ret_rd_val,
  input  logic [31:0] ret_rs_val,
  input  logic [31:0] ret_rt_val,
  input  logic [31:0] ret_v0,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_is_i,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [31:0] out_rd_val,
  output logic [31:0] out_rs_val,
  output logic [31:0] out_rt_val,
  output logic        stall_req,
  output logic        overflow,
  output logic        halt,
  output logic        drained,
  output logic [31:0] retired_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(0);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_HIGH  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   CNT_NEAR  = (AW+1)'(DEPTH - 2);

  typedef struct packed {
    logic        is_i;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rd_val;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
  } rec_t;

  rec_t          mem_q [DEPTH];
  rec_t          wr_rec_s;
  rec_t          head_s;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          stall_q, stall_d;
  logic          overflow_q, overflow_d;
  logic          halt_q, halt_d;
  logic [31:0]   retired_q, retired_d;

  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          accept_s;
  logic          drop_s;
  logic          halt_hit_s;

  // Handshake qualifiers and the record as it will be stored.
  always_comb begin
    push_s     = ret_valid & (ret_is_r | ret_is_i) & ~halt_q;
    pop_s      = out_valid & out_ready;
    full_s     = (count_q == CNT_FULL);
    // A full buffer still takes a push when the head leaves in the same cycle.
    accept_s   = push_s & (~full_s | pop_s);
    drop_s     = push_s & full_s & ~pop_s;
    // Halt detection looks at every retirement, logged class or not.
    halt_hit_s = ret_valid & (ret_instr == HALT_INSTR) & (ret_v0 == HALT_V0) & ~halt_q;

    wr_rec_s.is_i   = ret_is_i;
    wr_rec_s.pc     = ret_pc;
    wr_rec_s.instr  = ret_instr;
    wr_rec_s.rs     = ret_rs;
    wr_rec_s.rt     = ret_rt;
    wr_rec_s.rs_val = ret_rs_val;
    wr_rec_s.rt_val = ret_rt_val;
    // I-type instructions have no rd; store zeros rather than stale inputs.
    if (ret_is_i) begin
      wr_rec_s.rd     = 5'd0;
      wr_rec_s.rd_val = 32'd0;
    end else begin
      wr_rec_s.rd     = ret_rd;
      wr_rec_s.rd_val = ret_rd_val;
    end
  end

  // Next-state computation for pointers, occupancy and status flags.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    halt_d     = halt_q;
    retired_d  = retired_q;

    if (accept_s) begin
      wr_ptr_d  = wr_ptr_q + PTR_ONE;
      retired_d = retired_q + 32'd1;
    end else begin
      wr_ptr_d  = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (accept_s && !pop_s) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_s && !accept_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end

    if (drop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    if (halt_hit_s) begin
      halt_d = 1'b1;
    end else begin
      halt_d = halt_q;
    end

    // Raised one entry early so a core that honours it never overflows.
    stall_d = (count_q >= CNT_HIGH) |
              ((count_q == CNT_NEAR) & push_s & ~pop_s);
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= CNT_ZERO;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
      halt_q     <= 1'b0;
      retired_q  <= 32'd0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
      halt_q     <= halt_d;
      retired_q  <= retired_d;
    end
  end

  // Record storage; contents are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (reset && accept_s) begin
      mem_q[wr_ptr_q] <= wr_rec_s;
    end
  end

  // Head record and status outputs, all taken straight from registers.
  always_comb begin
    head_s      = mem_q[rd_ptr_q];
    out_valid   = (count_q != CNT_ZERO);
    out_is_i    = head_s.is_i;
    out_pc      = head_s.pc;
    out_instr   = head_s.instr;
    out_rd      = head_s.rd;
    out_rs      = head_s.rs;
    out_rt      = head_s.rt;
    out_rd_val  = head_s.rd_val;
    out_rs_val  = head_s.rs_val;
    out_rt_val  = head_s.rt_val;
    stall_req   = stall_q;
    overflow    = overflow_q;
    halt        = halt_q;
    drained     = halt_q & (count_q == CNT_ZERO);
    retired_cnt = retired_q;
  end

endmodule

// File: tb/tb_retire_trace_buf.sv
module tb_retire_trace_buf;

  typedef struct packed {
    logic        is_i;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rd_val;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ret_valid = 1'b0;
  logic        ret_is_r = 1'b0;
  logic        ret_is_i = 1'b0;
  logic [31:0] ret_pc = 32'd0;
  logic [31:0] ret_instr = 32'd0;
  logic [4:0]  ret_rd = 5'd0;
  logic [4:0]  ret_rs = 5'd0;
  logic [4:0]  ret_rt = 5'd0;
  logic [31:0] ret_rd_val = 32'd0;
  logic [31:0] ret_rs_val = 32'd0;
  logic [31:0] ret_rt_val = 32'd0;
  logic [31:0] ret_v0 = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_is_i;
  logic [31:0] out_pc, out_instr, out_rd_val, out_rs_val, out_rt_val;
  logic [4:0]  out_rd, out_rs, out_rt;
  logic        stall_req, overflow, halt, drained;
  logic [31:0] retired_cnt;

  int n_checks = 0;
  int n_errors = 0;
  rec_t exp_q[$];

  retire_trace_buf #(.DEPTH(8), .HALT_INSTR(32'h0000000c), .HALT_V0(32'h0000000a)) dut (
    .clk(clk), .reset(reset),
    .ret_valid(ret_valid), .ret_is_r(ret_is_r), .ret_is_i(ret_is_i),
    .ret_pc(ret_pc), .ret_instr(ret_instr),
    .ret_rd(ret_rd), .ret_rs(ret_rs), .ret_rt(ret_rt),
    .ret_rd_val(ret_rd_val), .ret_rs_val(ret_rs_val), .ret_rt_val(ret_rt_val),
    .ret_v0(ret_v0),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_i(out_is_i),
    .out_pc(out_pc), .out_instr(out_instr),
    .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
    .out_rd_val(out_rd_val), .out_rs_val(out_rs_val), .out_rt_val(out_rt_val),
    .stall_req(stall_req), .overflow(overflow), .halt(halt), .drained(drained),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: on the falling edge, a handshake about to complete is compared
  // against the oldest expected record.
  always @(negedge clk) begin
    rec_t act;
    rec_t exp;
    if (reset && out_valid && out_ready) begin
      act = {out_is_i, out_pc, out_instr, out_rd, out_rs, out_rt,
             out_rd_val, out_rs_val, out_rt_val};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_record: got pc=%h instr=%h with nothing expected", out_pc, out_instr);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_errors++;
          $display("FAIL record: got i=%0d pc=%h ins=%h rd=%0d rs=%0d rt=%0d rdv=%h rsv=%h rtv=%h expected i=%0d pc=%h ins=%h rd=%0d rs=%0d rt=%0d rdv=%h rsv=%h rtv=%h",
                   act.is_i, act.pc, act.instr, act.rd, act.rs, act.rt, act.rd_val, act.rs_val, act.rt_val,
                   exp.is_i, exp.pc, exp.instr, exp.rd, exp.rs, exp.rt, exp.rd_val, exp.rs_val, exp.rt_val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one retirement for one cycle; queue the expected record if it is accepted.
  task automatic retire(input logic is_r, input logic is_i,
                        input logic [31:0] pc, input logic [31:0] instr,
                        input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rdv, input logic [31:0] rsv, input logic [31:0] rtv,
                        input logic [31:0] v0, input bit acc, input rec_t exp);
    ret_valid = 1'b1; ret_is_r = is_r; ret_is_i = is_i;
    ret_pc = pc; ret_instr = instr;
    ret_rd = rd; ret_rs = rs; ret_rt = rt;
    ret_rd_val = rdv; ret_rs_val = rsv; ret_rt_val = rtv; ret_v0 = v0;
    if (acc) exp_q.push_back(exp);
    tick();
    ret_valid = 1'b0; ret_is_r = 1'b0; ret_is_i = 1'b0;
  endtask

  task automatic send_r(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                        input logic [31:0] rdv, input logic [31:0] v0, input bit acc);
    rec_t e;
    e = {1'b0, pc, instr, rd, 5'd9, 5'd10, rdv, 32'h00000002, 32'h00000003};
    retire(1'b1, 1'b0, pc, instr, rd, 5'd9, 5'd10, rdv, 32'h00000002, 32'h00000003, v0, acc, e);
  endtask

  task automatic send_i(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                        input logic [31:0] rdv, input logic [31:0] v0, input bit acc);
    rec_t e;
    e = {1'b1, pc, instr, 5'd0, 5'd4, 5'd5, 32'd0, 32'h00000011, 32'h00000022};
    retire(1'b0, 1'b1, pc, instr, rd, 5'd4, 5'd5, rdv, 32'h00000011, 32'h00000022, v0, acc, e);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    reset = 1'b0;
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_drained", {31'd0, drained}, 32'd0);
    chk("rst_retired", retired_cnt, 32'd0);
    reset = 1'b1;
    tick();

    // Single R-type record, visible for exactly one cycle
    out_ready = 1'b1;
    send_r(32'h00400000, 32'h012A4020, 5'd8, 32'h00000005, 32'd0, 1'b1);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_retired", retired_cnt, 32'd1);
    tick();
    chk("single_gone", {31'd0, out_valid}, 32'd0);

    // I-type record stores rd/rd_val as zero
    send_i(32'h00400004, 32'h2107FFFF, 5'd7, 32'h0000FFFF, 32'd0, 1'b1);
    tick();
    chk("itype_retired", retired_cnt, 32'd2);

    // Fill with the checker stalled
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      send_r(32'h00001000 + 32'(k) * 32'd4, 32'h00A00020 + 32'(k), 5'(k), 32'h00000100 + 32'(k), 32'd0, 1'b1);
      chk($sformatf("fill_stall_%0d", k), {31'd0, stall_req}, (k >= 7) ? 32'd1 : 32'd0);
    end
    chk("fill_retired", retired_cnt, 32'd10);
    chk("fill_no_overflow", {31'd0, overflow}, 32'd0);

    // Push with pop while full: accepted, no overflow
    out_ready = 1'b1;
    send_r(32'h00002000, 32'h00B00020, 5'd20, 32'h00000200, 32'd0, 1'b1);
    chk("pushpop_overflow", {31'd0, overflow}, 32'd0);
    chk("pushpop_retired", retired_cnt, 32'd11);
    chk("pushpop_valid", {31'd0, out_valid}, 32'd1);
    chk("pushpop_stall", {31'd0, stall_req}, 32'd1);

    // Push while full without pop: dropped
    out_ready = 1'b0;
    send_r(32'h00003000, 32'h00C00020, 5'd21, 32'h00000300, 32'd0, 1'b0);
    chk("drop_overflow", {31'd0, overflow}, 32'd1);
    chk("drop_retired", retired_cnt, 32'd11);

    // Drain: exactly eight records remain
    out_ready = 1'b1;
    repeat (7) tick();
    chk("drain_7_valid", {31'd0, out_valid}, 32'd1);
    tick();
    chk("drain_8_empty", {31'd0, out_valid}, 32'd0);
    chk("drain_stall", {31'd0, stall_req}, 32'd0);

    // Pointer wrap with back-to-back push/pop pairs
    for (int k = 0; k < 4; k++) begin
      send_r(32'h00004000 + 32'(k) * 32'd4, 32'h00D00020 + 32'(k), 5'(k + 1), 32'h00000400 + 32'(k), 32'd0, 1'b1);
    end
    tick();
    chk("wrap_empty", {31'd0, out_valid}, 32'd0);
    chk("wrap_retired", retired_cnt, 32'd15);

    // Neither R nor I: not logged
    begin
      rec_t none;
      none = '0;
      retire(1'b0, 1'b0, 32'h00005000, 32'h08000000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, none);
    end
    chk("none_retired", retired_cnt, 32'd15);
    chk("none_valid", {31'd0, out_valid}, 32'd0);

    // Halt instruction with wrong v0: logged, no halt
    send_r(32'h00006000, 32'h0000000c, 5'd0, 32'd0, 32'h00000009, 1'b1);
    chk("halt_wrong_v0", {31'd0, halt}, 32'd0);
    tick();

    // Real halt
    send_i(32'h00006004, 32'h0000000c, 5'd3, 32'h00000033, 32'h0000000a, 1'b1);
    chk("halt_set", {31'd0, halt}, 32'd1);
    chk("halt_not_drained", {31'd0, drained}, 32'd0);
    chk("halt_retired", retired_cnt, 32'd17);
    send_r(32'h00006008, 32'h012A4020, 5'd8, 32'h00000077, 32'd0, 1'b0);
    chk("after_halt_retired", retired_cnt, 32'd17);
    chk("after_halt_drained", {31'd0, drained}, 32'd1);
    chk("after_halt_valid", {31'd0, out_valid}, 32'd0);

    // Reset clears halt and count
    out_ready = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst2_halt", {31'd0, halt}, 32'd0);
    chk("rst2_retired", retired_cnt, 32'd0);

    // Build 5 buffered records with overflow set
    for (int k = 0; k < 9; k++) begin
      send_r(32'h00007000 + 32'(k) * 32'd4, 32'h00E00020 + 32'(k), 5'(k + 2), 32'h00000500 + 32'(k), 32'd0, (k < 8));
    end
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    chk("pre_rst_overflow", {31'd0, overflow}, 32'd1);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_retired", retired_cnt, 32'd8);

    // Mid-run reset
    reset = 1'b0;
    exp_q.delete();
    tick();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall_req}, 32'd0);
    chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    chk("mid_rst_halt", {31'd0, halt}, 32'd0);
    chk("mid_rst_drained", {31'd0, drained}, 32'd0);
    chk("mid_rst_retired", retired_cnt, 32'd0);
    reset = 1'b1;

    // Next push is the only record delivered
    out_ready = 1'b1;
    send_r(32'h00008000, 32'h01095020, 5'd10, 32'h0000ABCD, 32'd0, 1'b1);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_retired", retired_cnt, 32'd1);
    tick();
    chk("post_rst_empty", {31'd0, out_valid}, 32'd0);
    tick();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
